// File: rtl/mod_addsub_unit.sv
// Limb-serial modular add/subtract: PASS1 forms a +/- b, PASS2 forms the
// corrected value with p, and the result selects between the two.
module mod_addsub_unit #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LIMB  = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned NL = WIDTH / LIMB;
  localparam int unsigned CW = (NL > 1) ? $clog2(NL) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NL - 1);

  if (((WIDTH % LIMB) != 0) || (LIMB < 2)) begin : g_bad_param
    $error("mod_addsub_unit: WIDTH must be a multiple of LIMB and LIMB >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             k_q, k_d;
  logic             sel_q, sel_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] t_q, t_d;

  logic [IW-1:0]    lsb;
  logic             last_limb;
  logic             do_add;
  logic [LIMB-1:0]  x_limb;
  logic [LIMB-1:0]  y_limb;
  logic [LIMB:0]    limb_res;

  // One slice of the carry/borrow chain; bit LIMB is the outgoing carry or borrow.
  function automatic logic [LIMB:0] limb_op(input logic add, input logic [LIMB-1:0] x,
                                            input logic [LIMB-1:0] y, input logic cin);
    logic [LIMB:0] r;
    if (add) r = {1'b0, x} + {1'b0, y} + (LIMB+1)'(cin);
    else     r = {1'b0, x} - {1'b0, y} - (LIMB+1)'(cin);
    return r;
  endfunction

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    k_d       = k_q;
    sel_d     = sel_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    s_d       = s_q;
    t_d       = t_q;
    x_limb    = '0;
    y_limb    = '0;
    do_add    = 1'b0;
    limb_res  = '0;
    lsb       = IW'(cnt_q) * IW'(LIMB);
    last_limb = (cnt_q == LAST);

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          p_d     = p_i;
          cnt_d   = '0;
          cy_d    = 1'b0;
          state_d = PASS1;
        end
      end

      PASS1: begin
        x_limb   = a_q[lsb +: LIMB];
        y_limb   = b_q[lsb +: LIMB];
        do_add   = ~op_q;
        limb_res = limb_op(do_add, x_limb, y_limb, cy_q);
        s_d[lsb +: LIMB] = limb_res[LIMB-1:0];
        if (last_limb) begin
          k_d     = limb_res[LIMB];
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = PASS2;
        end else begin
          cy_d  = limb_res[LIMB];
          cnt_d = cnt_q + CW'(1);
        end
      end

      PASS2: begin
        x_limb   = s_q[lsb +: LIMB];
        y_limb   = p_q[lsb +: LIMB];
        do_add   = op_q;
        limb_res = limb_op(do_add, x_limb, y_limb, cy_q);
        t_d[lsb +: LIMB] = limb_res[LIMB-1:0];
        if (last_limb) begin
          // add: no final borrow (or a WIDTH carry-out) means a + b >= p
          sel_d   = op_q ? k_q : (k_q | ~limb_res[LIMB]);
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cy_d  = limb_res[LIMB];
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cy_q        <= 1'b0;
      k_q         <= 1'b0;
      sel_q       <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      s_q         <= '0;
      t_q         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      result_o    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cy_q        <= cy_d;
      k_q         <= k_d;
      sel_q       <= sel_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      s_q         <= s_d;
      t_q         <= t_d;
      in_ready_o  <= (state_d == IDLE);
      out_valid_o <= (state_d == DONE);
      if (state_d == DONE) result_o <= sel_d ? t_d : s_d;
    end
  end

endmodule

// File: tb/tb_mod_addsub_unit.sv
// Randomised and directed check of mod_addsub_unit against a plain-arithmetic
// model of the modular result and of the handshake timing.
module tb_mod_addsub_unit;

  localparam int unsigned W    = 256;
  localparam int unsigned LIMB = 64;
  localparam int unsigned NL   = W / LIMB;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready_o;
  logic         op;
  logic [W-1:0] a, b, p;
  logic         out_valid_o;
  logic         out_ready;
  logic [W-1:0] result_o;

  logic         lit_en;
  logic [W-1:0] lit_val;

  int vectors;
  int miscompares;

  mod_addsub_unit #(.WIDTH(W), .LIMB(LIMB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .p_i         (p),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .result_o    (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_f(input logic o, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic [W-1:0] m);
    logic [W:0] sum;
    if (!o) begin
      sum = {1'b0, x} + {1'b0, y};
      if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
      return sum[W-1:0];
    end
    if (x < y) return x - y + m;
    return x - y;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W / 32); i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL timeout waiting for %s", nm);
  endtask

  // Reference model: idle / busy for 2*NL edges / done until out_ready
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_e;
  mphase_e      m_st;
  int           m_cnt;
  logic         m_live;
  logic         m_rst_chk;
  logic [W-1:0] m_exp;
  logic         m_lit_en;
  logic [W-1:0] m_lit;

  initial begin
    m_st = M_IDLE; m_cnt = 0; m_live = 1'b0; m_rst_chk = 1'b0;
    m_exp = '0; m_lit_en = 1'b0; m_lit = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_st = M_IDLE; m_cnt = 0; m_live = 1'b1; m_rst_chk = 1'b1;
      end else begin
        m_rst_chk = 1'b0;
        case (m_st)
          M_IDLE: if (in_valid) begin
            m_exp = ref_f(op, a, b, p);
            m_lit_en = lit_en; m_lit = lit_val;
            m_cnt = 0; m_st = M_BUSY;
          end
          M_BUSY: begin
            m_cnt++;
            if (m_cnt == int'(2 * NL)) m_st = M_DONE;
          end
          default: if (out_ready) m_st = M_IDLE;
        endcase
      end
      @(negedge clk);
      if (m_live) begin
        chk("in_ready", W'(in_ready_o), W'(m_st == M_IDLE));
        chk("out_valid", W'(out_valid_o), W'(m_st == M_DONE));
        if (m_st == M_DONE) begin
          chk("result_model", result_o, m_exp);
          if (m_lit_en) chk("result_literal", result_o, m_lit);
        end
        if (m_rst_chk) chk("result_after_reset", result_o, '0);
      end
    end
  end

  // Drive a request and return #1 after the accepting edge
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] m, input logic le, input logic [W-1:0] lv,
                       output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!in_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready_o) begin timeout("in_ready"); return; end
    op = o; a = x; b = y; p = m; lit_en = le; lit_val = lv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_valid(output logic ok);
    int n;
    n = 0;
    while (!out_valid_o && n < 100) begin @(posedge clk); #1; n++; end
    ok = out_valid_o;
    if (!ok) timeout("out_valid");
  endtask

  // Full operation; during the hold cycles a stray request is offered and must be ignored
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] m, input logic le, input logic [W-1:0] lv,
                        input int hold);
    logic ok;
    issue(o, x, y, m, le, lv, ok);
    if (!ok) return;
    wait_valid(ok);
    if (!ok) return;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = rand_w(); b = rand_w(); op = ~op;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p25519, pbig, one, ra, rb, rp;
    logic         ok;
    logic         ro;
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; p = '0;
    out_ready = 1'b0; lit_en = 1'b0; lit_val = '0;
    one    = W'(1);
    p25519 = (one << 255) - W'(19);
    pbig   = '1 - W'(188);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // add, carry across a limb boundary
    run_op(1'b0, (one << 64) - one, one, p25519, 1'b1, one << 64, 0);
    // add with reduction
    run_op(1'b0, W'(10), W'(7), W'(13), 1'b1, W'(4), 0);
    run_op(1'b0, W'(5),  W'(7), W'(13), 1'b1, W'(12), 1);
    run_op(1'b0, W'(6),  W'(7), W'(13), 1'b1, W'(0), 0);
    // WIDTH-bit carry-out must force the corrected value
    run_op(1'b0, pbig - one, pbig - one, pbig, 1'b1, pbig - W'(2), 0);
    // p = 0 in add mode wraps mod 2^WIDTH
    run_op(1'b0, '1, W'(2), '0, 1'b1, one, 0);
    // subtract
    run_op(1'b1, W'(3),  W'(10), W'(13), 1'b1, W'(6), 0);
    run_op(1'b1, W'(10), W'(3),  W'(13), 1'b1, W'(7), 0);
    run_op(1'b1, W'(12), W'(12), W'(13), 1'b1, W'(0), 0);
    run_op(1'b1, one << 64, one, p25519, 1'b1, (one << 64) - one, 0);
    // backpressure then back-to-back request
    run_op(1'b0, W'(9), W'(11), W'(13), 1'b1, W'(7), 5);
    run_op(1'b0, W'(10), W'(7), W'(13), 1'b1, W'(4), 0);

    // reset during PASS1 with cnt = 2
    issue(1'b0, rand_w(), rand_w(), p25519, 1'b0, '0, ok);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset();
    run_op(1'b0, W'(10), W'(7), W'(13), 1'b1, W'(4), 0);

    // reset in DONE while stalled
    issue(1'b1, rand_w(), rand_w(), pbig, 1'b0, '0, ok);
    wait_valid(ok);
    repeat (2) begin @(posedge clk); #1; end
    pulse_reset();
    run_op(1'b0, W'(10), W'(7), W'(13), 1'b1, W'(4), 0);

    // randomised operations
    for (int i = 0; i < 80; i++) begin
      ro = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin
          rp = rand_w(); if (rp == '0) rp = one;
          ra = rand_w() % rp; rb = rand_w() % rp;
        end
        1: begin ra = rand_w(); rb = rand_w(); rp = rand_w(); end
        2: begin
          rp = W'($urandom_range(1, 1000));
          ra = W'($urandom) % rp; rb = W'($urandom) % rp;
        end
        default: begin
          ra = rand_w(); rp = rand_w();
          rb = ro ? ra : rand_w();
          if (!ro) rp = '0;
        end
      endcase
      run_op(ro, ra, rb, rp, 1'b0, '0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
